// File: rtl/bcd_countdown_timer_if.sv
// Bundle of the set-time input and the display/buzzer-facing outputs of
// bcd_countdown_timer. The master side drives the controls, the slave side
// is the timer itself.
interface bcd_countdown_timer_if;
    logic [7:0] set_t;    // BCD setting, [7:4] tens, [3:0] units
    logic       start;    // start / resume / restart pulse
    logic       pause;    // freeze a running countdown
    logic       clear;    // abort to IDLE
    logic [7:0] remain;   // BCD remaining count
    logic       running;  // high in RUN
    logic       paused;   // high in PAUSE
    logic       done;     // one-cycle pulse on reaching 00
    logic       alarm;    // high while in DONE
    logic       err;      // one-cycle pulse on a rejected start

    modport master (
        output set_t, start, pause, clear,
        input  remain, running, paused, done, alarm, err
    );

    modport slave (
        input  set_t, start, pause, clear,
        output remain, running, paused, done, alarm, err
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer. Loads the set-time value on start, counts
// it down once every TICK_DIV clock cycles, pulses done and raises alarm at
// 00. Pause freezes the prescaler and count; resume continues the partial
// tick. While idle the remaining-count output mirrors the setting.
// Optional build macro TIMER_SET_CHECK_EN: reject starts whose setting is
// not valid BCD or lies outside 01..60, pulsing err instead.
module bcd_countdown_timer #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_countdown_timer_if.slave tmr
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    remain_q, remain_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic set_nonzero;
    logic set_ok;
    logic start_ok;
    logic start_reject;

    // One BCD step down; callers never apply it to 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) begin
            return {v[7:4] - 4'd1, 4'd9};
        end
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign set_nonzero = (tmr.set_t != 8'h00);

`ifdef TIMER_SET_CHECK_EN
    // For valid BCD the byte ordering matches the numeric ordering.
    assign set_ok = (tmr.set_t[7:4] <= 4'd9) && (tmr.set_t[3:0] <= 4'd9) &&
                    (tmr.set_t >= 8'h01) && (tmr.set_t <= 8'h60);
`else
    assign set_ok = 1'b1;
`endif

    // A zero setting is silently ignored; only a non-zero bad setting errs.
    assign start_ok     = tmr.start && set_nonzero && set_ok;
    assign start_reject = tmr.start && set_nonzero && !set_ok;

    // Next-state logic: clear beats pause beats start; pause only acts in RUN.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        presc_d  = presc_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (tmr.clear) begin
            state_d  = ST_IDLE;
            remain_d = tmr.set_t;
            presc_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    remain_d = tmr.set_t;
                    if (start_ok) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end else if (start_reject) begin
                        err_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (tmr.pause) begin
                        state_d = ST_PAUSE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (remain_q == 8'h01) begin
                            remain_d = 8'h00;
                            done_d   = 1'b1;
                            state_d  = ST_DONE;
                        end else begin
                            remain_d = bcd_dec(remain_q);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    // Resume keeps the held prescaler value.
                    if (tmr.start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (start_ok) begin
                        state_d  = ST_RUN;
                        remain_d = tmr.set_t;
                        presc_d  = '0;
                    end else if (start_reject) begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            remain_q <= 8'h00;
            presc_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            presc_q  <= presc_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Status flags are pure decodes of the state register.
    assign tmr.remain  = remain_q;
    assign tmr.running = (state_q == ST_RUN);
    assign tmr.paused  = (state_q == ST_PAUSE);
    assign tmr.alarm   = (state_q == ST_DONE);
    assign tmr.done    = done_q;
    assign tmr.err     = err_q;
endmodule
